// File: rtl/misr_pkg.sv
// misr_pkg: shared definitions for the response MISR compactor.
//   state_e   : session FSM encoding (IDLE, RUN, CHECK, DONE)
//   DEF_POLY  : default Galois feedback polynomial (x^16 implicit)
//   DEF_SEED  : default MISR seed
//   misr_next : one MISR step, width-generic up to 64 bits; the RTL core and
//               the bench reference model both call it.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'hFFFF;
  localparam int          MAX_SIG_W = 64;

  // Galois step: shift left, fold POLY in when the outgoing MSB was set,
  // then XOR the (already zero-extended) response word. Result is masked
  // to sig_w bits so callers may slice the low bits freely.
  function automatic logic [63:0] misr_next(input logic [63:0] sig,
                                            input logic [63:0] data,
                                            input logic [63:0] poly,
                                            input int          sig_w);
    logic [63:0] mask;
    logic [63:0] nxt;
    mask = (sig_w >= MAX_SIG_W) ? '1 : ((64'd1 << sig_w) - 64'd1);
    nxt  = (sig << 1) ^ data;
    if (sig[sig_w-1]) nxt = nxt ^ poly;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// misr_core: SIG_W-bit multiple-input signature register.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   load     : reseed with SEED (wins over inject)
//   inject   : fold data into the signature this edge
//   data     : zero-extended response word
//   sig      : current signature
// SIG_W must not exceed 64 (width of the shared step function).
module misr_core
  import misr_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inject,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [63:0] nxt_wide;

  assign nxt_wide = misr_next(64'(sig), 64'(data), 64'(POLY), SIG_W);

  // The step function masks its result, so the upper bits are always zero.
  generate
    if (SIG_W < 64) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nxt_wide[63:SIG_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || load) sig <= SEED;
    else if (inject) sig <= nxt_wide[SIG_W-1:0];
  end

endmodule

// File: rtl/resp_misr_compactor.sv
// resp_misr_compactor: BIST output-response compactor. Folds one CUT
// response per handshake into a MISR, counts NPAT responses, then compares
// the signature with golden and reports pass/fail.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle session start (honoured in IDLE and DONE)
//   resp_valid/ready, resp_data : response handshake (bit 0 = first output)
//   resp_xmask    : per-bit X mask, present only with MISR_XMASK_EN defined
//   golden        : expected signature, sampled in CHECK
//   busy, done, pass, signature, pat_cnt : status back to the controller
// Build option: `define MISR_XMASK_EN adds resp_xmask; masked bits are
// injected as 0 but the beat still counts.
module resp_misr_compactor
  import misr_pkg::*;
#(
  parameter int               RESP_W = 1,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
  parameter int               NPAT   = 16,
  localparam int              CNT_W  = $clog2(NPAT+1)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
`ifdef MISR_XMASK_EN
  input  logic [RESP_W-1:0] resp_xmask,
`endif
  input  logic [SIG_W-1:0]  golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  pat_cnt
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state;
  logic              accept;
  logic              load;
  logic [RESP_W-1:0] inj;
  logic [SIG_W-1:0]  inj_ext;

  assign resp_ready = (state == S_RUN);
  assign busy       = (state == S_RUN) || (state == S_CHECK);
  assign done       = (state == S_DONE);
  assign accept     = resp_ready && resp_valid;
  assign load       = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef MISR_XMASK_EN
  assign inj = resp_data & ~resp_xmask;
`else
  assign inj = resp_data;
`endif

  always_comb begin
    inj_ext             = '0;
    inj_ext[RESP_W-1:0] = inj;
  end

  misr_core #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .inject (accept),
    .data   (inj_ext),
    .sig    (signature)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pat_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state   <= S_RUN;
          pat_cnt <= '0;
          pass    <= 1'b0;
        end
        S_RUN: if (accept) begin
          pat_cnt <= pat_cnt + CNT_W'(1);
          // Last beat of the session: counter stops at NPAT, never wraps.
          if (pat_cnt == CNT_W'(NPAT-1)) state <= S_CHECK;
        end
        S_CHECK: begin
          pass  <= (signature == golden);
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_compactor.sv
module tb_resp_misr_compactor;
  import misr_pkg::*;

  typedef struct {
    int          id;
    logic [15:0] sig;
    logic        pass;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  st, vl, dt;
  logic [15:0] gd [3];
  wire  [2:0]  rd, by, dn, ps;
  wire  [15:0] sg [3];
  wire  [4:0]  cn [3];
  wire  [4:0]  a_cnt;
  wire  [0:0]  b_cnt, c_cnt;
`ifdef MISR_XMASK_EN
  logic [2:0]  xm;
`endif

  int   checks = 0, failures = 0, cyc = 0;
  exp_t q[$];
  int   acc_cyc [3];
  logic [2:0] dn_d = 3'b0;

  // a: default session (NPAT=16, SEED=FFFF); b/c: single-beat sessions.
  resp_misr_compactor dut_a (
    .clk(clk), .rst(rst), .start(st[0]), .resp_valid(vl[0]), .resp_ready(rd[0]),
    .resp_data(dt[0:0]),
`ifdef MISR_XMASK_EN
    .resp_xmask(xm[0:0]),
`endif
    .golden(gd[0]), .busy(by[0]), .done(dn[0]), .pass(ps[0]),
    .signature(sg[0]), .pat_cnt(a_cnt));

  resp_misr_compactor #(.NPAT(1), .SEED(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .start(st[1]), .resp_valid(vl[1]), .resp_ready(rd[1]),
    .resp_data(dt[1:1]),
`ifdef MISR_XMASK_EN
    .resp_xmask(xm[1:1]),
`endif
    .golden(gd[1]), .busy(by[1]), .done(dn[1]), .pass(ps[1]),
    .signature(sg[1]), .pat_cnt(b_cnt));

  resp_misr_compactor #(.NPAT(1), .SEED(16'h8000)) dut_c (
    .clk(clk), .rst(rst), .start(st[2]), .resp_valid(vl[2]), .resp_ready(rd[2]),
    .resp_data(dt[2:2]),
`ifdef MISR_XMASK_EN
    .resp_xmask(xm[2:2]),
`endif
    .golden(gd[2]), .busy(by[2]), .done(dn[2]), .pass(ps[2]),
    .signature(sg[2]), .pat_cnt(c_cnt));

  assign cn[0] = a_cnt;
  assign cn[1] = {4'd0, b_cnt};
  assign cn[2] = {4'd0, c_cnt};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic nand_bit(input int i);
    logic [3:0] p;
    p = 4'(i);
    return ~&p;
  endfunction

  function automatic logic [15:0] model_sig(input int flip);
    logic [63:0] s;
    logic        d;
    s = 64'(16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      d = nand_bit(i);
      if (i == flip) d = ~d;
      s = misr_next(s, 64'(d), 64'(16'h1021), 16);
    end
    return s[15:0];
  endfunction

  // Scoreboard monitor: on each done rise pop that instance's expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   found;
    for (int i = 0; i < 3; i++) begin
      if (vl[i] && rd[i]) acc_cyc[i] <= cyc;
      if (dn[i] && !dn_d[i]) begin
        found = 0;
        for (int k = 0; k < q.size(); k++) begin
          if (!found && q[k].id == i) begin
            e = q[k];
            q.delete(k);
            found = 1;
          end
        end
        chk($sformatf("sb_expected_%0d", i), 64'(found), 64'(1));
        if (found) begin
          chk($sformatf("sig_%0d", i),  64'(sg[i]), 64'(e.sig));
          chk($sformatf("pass_%0d", i), 64'(ps[i]), 64'(e.pass));
          chk($sformatf("cnt_%0d", i),  64'(cn[i]), 64'(e.cnt));
          chk($sformatf("latency_%0d", i), 64'(cyc - acc_cyc[i]), 64'(2));
        end
      end
    end
    dn_d <= dn;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_pulse(input int id);
    st[id] = 1'b1;
    step();
    st[id] = 1'b0;
  endtask

  task automatic beat(input int id, input logic d, input int gap);
    int n;
    vl[id] = 1'b0;
    repeat (gap) step();
    vl[id] = 1'b1;
    dt[id] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd[id] && n < 20);
    if (!rd[id]) chk("beat_timeout", 64'(rd[id]), 64'(1));
    step();
    vl[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (!dn[id] && n < 40) begin step(); n++; end
    if (!dn[id]) chk("done_timeout", 64'(dn[id]), 64'(1));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st = '0; vl = '0; dt = '0;
    for (int i = 0; i < 3; i++) gd[i] = '0;
`ifdef MISR_XMASK_EN
    xm = '0;
`endif
    repeat (2) step();
    @(negedge clk);
    chk("rst_sig_a",   64'(sg[0]), 64'(16'hFFFF));
    chk("rst_cnt_a",   64'(cn[0]), 64'(0));
    chk("rst_busy_a",  64'(by[0]), 64'(0));
    chk("rst_done_a",  64'(dn[0]), 64'(0));
    chk("rst_pass_a",  64'(ps[0]), 64'(0));
    chk("rst_ready_a", 64'(rd[0]), 64'(0));
    chk("rst_sig_b",   64'(sg[1]), 64'(16'h0000));
    chk("rst_sig_c",   64'(sg[2]), 64'(16'h8000));
    step();
    rst = 1'b0;

    // Responses offered in IDLE are not consumed.
    vl[0] = 1'b1; dt[0] = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(rd[0]), 64'(0));
    step();
    @(negedge clk);
    chk("idle_cnt", 64'(cn[0]), 64'(0));
    chk("idle_sig", 64'(sg[0]), 64'(16'hFFFF));
    step();
    vl[0] = 1'b0;

    // Single beat, SEED=0, data=1 -> 0001, pass.
    gd[1] = 16'h0001;
    q.push_back('{1, 16'h0001, 1'b1, 1});
    start_pulse(1);
    beat(1, 1'b1, 0);
    wait_done(1);

    // Single beat through feedback: 8000 -> 1021, golden mismatch.
    gd[2] = 16'h1020;
    q.push_back('{2, 16'h1021, 1'b0, 1});
    start_pulse(2);
    beat(2, 1'b0, 0);
    wait_done(2);

    // Exhaustive NAND session with gaps and an ignored mid-run start.
    gd[0] = model_sig(-1);
    q.push_back('{0, gd[0], 1'b1, 16});
    start_pulse(0);
    for (int i = 0; i < 16; i++) begin
      beat(0, nand_bit(i), int'($urandom_range(0, 2)));
      if (i == 5) start_pulse(0);
    end
    // Now in CHECK: offers stay unconsumed through CHECK and DONE.
    vl[0] = 1'b1;
    @(negedge clk);
    chk("check_ready", 64'(rd[0]), 64'(0));
    chk("check_busy",  64'(by[0]), 64'(1));
    step();
    @(negedge clk);
    chk("done_ready", 64'(rd[0]), 64'(0));
    chk("done_flag",  64'(dn[0]), 64'(1));
    chk("done_busy",  64'(by[0]), 64'(0));
    step(); step();
    @(negedge clk);
    chk("frozen_cnt", 64'(cn[0]), 64'(16));
    chk("frozen_sig", 64'(sg[0]), 64'(gd[0]));
    step();
    vl[0] = 1'b0;

    // Restart from DONE reseeds; one flipped response bit must fail.
    start_pulse(0);
    @(negedge clk);
    chk("reseed_sig",  64'(sg[0]), 64'(16'hFFFF));
    chk("reseed_cnt",  64'(cn[0]), 64'(0));
    chk("reseed_done", 64'(dn[0]), 64'(0));
    step();
    q.push_back('{0, model_sig(3), 1'b0, 16});
    for (int i = 0; i < 16; i++)
      beat(0, nand_bit(i) ^ (i == 3), int'($urandom_range(0, 1)));
    wait_done(0);

    // Reset after 7 accepts aborts the session.
    start_pulse(0);
    for (int i = 0; i < 7; i++) beat(0, nand_bit(i), 0);
    @(negedge clk);
    chk("mid_cnt", 64'(cn[0]), 64'(7));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sig",  64'(sg[0]), 64'(16'hFFFF));
    chk("abort_cnt",  64'(cn[0]), 64'(0));
    chk("abort_done", 64'(dn[0]), 64'(0));
    chk("abort_pass", 64'(ps[0]), 64'(0));
    chk("abort_busy", 64'(by[0]), 64'(0));
    step();

`ifdef MISR_XMASK_EN
    // Masked beat: data=1 but mask=1 -> nothing injected, count still moves.
    xm[1] = 1'b1;
    q.push_back('{1, 16'h0000, 1'b0, 1});
    start_pulse(1);
    beat(1, 1'b1, 0);
    wait_done(1);
    xm[1] = 1'b0;
`endif

    repeat (3) step();
    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
